// File: rtl/counter_pkg.sv
// Shared constants and helpers for the generic counter/timebase blocks.
package counter_pkg;

    localparam int unsigned CNT_WRAP = 0;
    localparam int unsigned CNT_SAT  = 1;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input longint unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 64; i++) begin
            if ((64'(1) << i) < v) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_prescaler.sv
// Enable-gated divider: asserts step on every PRESCALE-th enabled cycle.
module clk_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sync_clr,
    output logic step
);

    localparam int unsigned PW = (clog2(64'(PRESCALE)) < 1) ? 1 : clog2(64'(PRESCALE));
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          at_last;

    assign at_last = (pre_q == LAST);
    assign step    = en && at_last;

    // Phase only advances while enabled, so a paused count resumes in place.
    always_comb begin
        pre_d = pre_q;
        if (sync_clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = at_last ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/prog_mod_counter.sv
// Configurable modulo up/down counter with prescaler, wrap/saturate mode,
// and registered terminal-count, zero and saturation flags.
module prog_mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MOD      = 256,
    parameter int unsigned     PRESCALE = 1,
    parameter int unsigned     SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             zero,
    output logic             sat
);

    // One extra bit so MOD == 2**WIDTH compares correctly.
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH + 1)'(MOD - 1);
    localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MOD - 1);
    localparam bit               SAT_MODE = (SATURATE == CNT_SAT);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             zero_q, zero_d;
    logic             sat_q, sat_d;
    logic             step;
    logic             at_max;
    logic             at_min;
    logic [WIDTH-1:0] load_clamped;

    clk_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync_clr (clr || load),
        .step     (step)
    );

    assign at_max       = ({1'b0, cnt_q} == MAX_EXT);
    assign at_min       = (cnt_q == '0);
    assign load_clamped = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_CNT;

    // Priority: clr > load > step > hold.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        sat_d = sat_q;
        if (clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (load) begin
            cnt_d = load_clamped;
            sat_d = SAT_MODE && ((up_dn == DIR_UP) ? (load_clamped == MAX_CNT)
                                                   : (load_clamped == '0));
        end else if (step) begin
            if (up_dn == DIR_UP) begin
                if (!at_max) begin
                    cnt_d = cnt_q + WIDTH'(1);
                    tc_d  = SAT_MODE && (cnt_d == MAX_CNT);
                    sat_d = tc_d;
                end else if (SAT_MODE) begin
                    tc_d  = !sat_q;
                    sat_d = 1'b1;
                end else begin
                    cnt_d = '0;
                    tc_d  = 1'b1;
                end
            end else begin
                if (!at_min) begin
                    cnt_d = cnt_q - WIDTH'(1);
                    tc_d  = SAT_MODE && (cnt_d == '0);
                    sat_d = tc_d;
                end else if (SAT_MODE) begin
                    tc_d  = !sat_q;
                    sat_d = 1'b1;
                end else begin
                    cnt_d = MAX_CNT;
                    tc_d  = 1'b1;
                end
            end
        end
        zero_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tc_q   <= 1'b0;
            zero_q <= 1'b1;
            sat_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tc_q   <= tc_d;
            zero_q <= zero_d;
            sat_q  <= sat_d;
        end
    end

    assign cnt  = cnt_q;
    assign tc   = tc_q;
    assign zero = zero_q;
    assign sat  = sat_q;

endmodule

// File: tb/tb_prog_mod_counter.sv
// Directed bench for prog_mod_counter across several parameter sets.
module tb_prog_mod_counter;

    logic clk;
    logic rst_n;

    logic       en0, up0, clr0, ld0;
    logic [7:0] lv0, c0;
    logic       tc0, z0, s0;

    logic       en1, up1, clr1, ld1;
    logic [7:0] lv1, c1;
    logic       tc1, z1, s1;

    logic       en2, up2, clr2, ld2;
    logic [7:0] lv2, c2;
    logic       tc2, z2, s2;

    logic       en3, up3, clr3, ld3;
    logic [7:0] lv3, c3;
    logic       tc3, z3, s3;

    logic       en4, up4, clr4, ld4;
    logic [3:0] lv4, c4;
    logic       tc4, z4, s4;

    int checks = 0;
    int errors = 0;
    int n1     = 0;

    int c2_exp[5] = '{8, 9, 9, 9, 9};
    int t2_exp[5] = '{0, 1, 0, 0, 0};
    int s2_exp[5] = '{0, 1, 1, 1, 1};

    prog_mod_counter u0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .up_dn(up0), .clr(clr0), .load(ld0),
        .load_val(lv0), .cnt(c0), .tc(tc0), .zero(z0), .sat(s0)
    );

    prog_mod_counter #(.WIDTH(8), .MOD(10), .PRESCALE(3), .SATURATE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .up_dn(up1), .clr(clr1), .load(ld1),
        .load_val(lv1), .cnt(c1), .tc(tc1), .zero(z1), .sat(s1)
    );

    prog_mod_counter #(.WIDTH(8), .MOD(10), .PRESCALE(1), .SATURATE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .up_dn(up2), .clr(clr2), .load(ld2),
        .load_val(lv2), .cnt(c2), .tc(tc2), .zero(z2), .sat(s2)
    );

    prog_mod_counter #(.WIDTH(8), .MOD(10), .PRESCALE(1), .SATURATE(0)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .up_dn(up3), .clr(clr3), .load(ld3),
        .load_val(lv3), .cnt(c3), .tc(tc3), .zero(z3), .sat(s3)
    );

    prog_mod_counter #(.WIDTH(4), .MOD(16), .PRESCALE(1), .SATURATE(0)) u4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .up_dn(up4), .clr(clr4), .load(ld4),
        .load_val(lv4), .cnt(c4), .tc(tc4), .zero(z4), .sat(s4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // u1 expectation follows the number of enabled cycles seen so far.
    task automatic tick_u1(input logic e);
        en1 = e;
        tick();
        if (e) n1++;
        chk("u1_cnt", 32'(c1), 32'((n1 / 3) % 10));
        chk("u1_tc", 32'(tc1), 32'(e && (n1 % 3 == 0) && ((n1 / 3) % 10 == 0)));
    endtask

    initial begin
        rst_n = 1'b0;
        {en0, clr0, ld0} = '0; up0 = 1'b1; lv0 = '0;
        {en1, clr1, ld1} = '0; up1 = 1'b1; lv1 = '0;
        {en2, clr2, ld2} = '0; up2 = 1'b1; lv2 = '0;
        {en3, clr3, ld3} = '0; up3 = 1'b1; lv3 = '0;
        {en4, clr4, ld4} = '0; up4 = 1'b1; lv4 = '0;

        tick();
        tick();
        chk("rst_cnt", 32'(c0), 32'd0);
        chk("rst_zero", 32'(z0), 32'd1);
        chk("rst_tc", 32'(tc0), 32'd0);
        chk("rst_sat", 32'(s0), 32'd0);
        chk("rst_cnt4", 32'(c4), 32'd0);

        // Default configuration: free-running 8-bit up counter.
        rst_n = 1'b1;
        en0   = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            tick();
            chk("u0_cnt", 32'(c0), 32'(k % 256));
            chk("u0_tc", 32'(tc0), 32'(k % 256 == 0));
            chk("u0_zero", 32'(z0), 32'(k % 256 == 0));
        end
        chk("u0_sat", 32'(s0), 32'd0);
        en0 = 1'b0;

        // Prescale by 3, wrap, then pause mid-phase.
        for (int k = 0; k < 34; k++) tick_u1(1'b1);
        for (int k = 0; k < 5; k++) tick_u1(1'b0);
        for (int k = 0; k < 12; k++) tick_u1(1'b1);
        chk("u1_pre_rst_cnt", 32'(c1), 32'd5);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_cnt", 32'(c1), 32'd0);
        chk("async_zero", 32'(z1), 32'd1);
        chk("async_tc", 32'(tc1), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_e1", 32'(c1), 32'd0);
        tick();
        chk("post_rst_e2", 32'(c1), 32'd0);
        tick();
        chk("post_rst_e3", 32'(c1), 32'd1);
        chk("post_rst_zero", 32'(z1), 32'd0);
        en1 = 1'b0;

        // Saturating mode: load 7 and count up into the limit.
        ld2 = 1'b1; lv2 = 8'd7;
        tick();
        chk("u2_load_cnt", 32'(c2), 32'd7);
        chk("u2_load_sat", 32'(s2), 32'd0);
        ld2 = 1'b0; en2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("u2_up_cnt", 32'(c2), 32'(c2_exp[k]));
            chk("u2_up_tc", 32'(tc2), 32'(t2_exp[k]));
            chk("u2_up_sat", 32'(s2), 32'(s2_exp[k]));
        end
        up2 = 1'b0;
        tick();
        chk("u2_dn_cnt", 32'(c2), 32'd8);
        chk("u2_dn_sat", 32'(s2), 32'd0);
        chk("u2_dn_tc", 32'(tc2), 32'd0);

        // Saturating at zero: attempt past the lower limit.
        en2 = 1'b0; clr2 = 1'b1;
        tick();
        chk("u2_clr_cnt", 32'(c2), 32'd0);
        chk("u2_clr_zero", 32'(z2), 32'd1);
        clr2 = 1'b0; en2 = 1'b1;
        tick();
        chk("u2_min_cnt", 32'(c2), 32'd0);
        chk("u2_min_tc", 32'(tc2), 32'd1);
        chk("u2_min_sat", 32'(s2), 32'd1);
        tick();
        chk("u2_min_tc2", 32'(tc2), 32'd0);
        chk("u2_min_sat2", 32'(s2), 32'd1);
        up2 = 1'b1;
        tick();
        chk("u2_leave_cnt", 32'(c2), 32'd1);
        chk("u2_leave_sat", 32'(s2), 32'd0);
        en2 = 1'b0;

        // Wrap mode counting down from reset, then load clamp and clr priority.
        en3 = 1'b1; up3 = 1'b0;
        tick();
        chk("u3_wrap_cnt", 32'(c3), 32'd9);
        chk("u3_wrap_tc", 32'(tc3), 32'd1);
        chk("u3_wrap_zero", 32'(z3), 32'd0);
        tick();
        chk("u3_dn8_cnt", 32'(c3), 32'd8);
        chk("u3_dn8_tc", 32'(tc3), 32'd0);
        tick();
        chk("u3_dn7_cnt", 32'(c3), 32'd7);
        en3 = 1'b0;
        ld3 = 1'b1; lv3 = 8'd15;
        tick();
        chk("u3_clamp15", 32'(c3), 32'd9);
        lv3 = 8'd10;
        tick();
        chk("u3_clamp10", 32'(c3), 32'd9);
        lv3 = 8'd4;
        tick();
        chk("u3_load4", 32'(c3), 32'd4);
        lv3 = 8'd3; clr3 = 1'b1;
        tick();
        chk("u3_clr_over_ld", 32'(c3), 32'd0);
        chk("u3_clr_zero", 32'(z3), 32'd1);
        chk("u3_sat", 32'(s3), 32'd0);
        ld3 = 1'b0; clr3 = 1'b0;

        // Full-range modulus: WIDTH=4, MOD=16.
        ld4 = 1'b1; lv4 = 4'd14;
        tick();
        chk("u4_load", 32'(c4), 32'd14);
        ld4 = 1'b0; en4 = 1'b1;
        tick();
        chk("u4_15_cnt", 32'(c4), 32'd15);
        chk("u4_15_tc", 32'(tc4), 32'd0);
        tick();
        chk("u4_wrap_cnt", 32'(c4), 32'd0);
        chk("u4_wrap_tc", 32'(tc4), 32'd1);
        chk("u4_wrap_zero", 32'(z4), 32'd1);
        tick();
        chk("u4_1_cnt", 32'(c4), 32'd1);
        chk("u4_1_tc", 32'(tc4), 32'd0);
        chk("u4_sat", 32'(s4), 32'd0);
        en4 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
